// File: rtl/event_packet_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : event_packet_transmitter
// Purpose  : Samples 8 pad lines and sends one 8N1 UART byte (LSB first) on
//            any input change, on a periodic refresh, or on a forced request.
//            Optional macro EVENT_TX_DEBOUNCE_EN adds per-bit debouncing.
// Revision : 1.0 - initial release
// ============================================================================
module event_packet_transmitter #(
    parameter int CLKS_PER_BIT    = 10416,
    parameter int REFRESH_CYCLES  = 5000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pad_in,
    input  logic       force_send,
    output logic       TxD,
    output logic       busy,
    output logic       sent_pulse,
    output logic [7:0] last_sent
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TW-1:0] C_BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] C_REF_LAST = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    generate
        if (CLKS_PER_BIT < 1 || REFRESH_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
            $error("event_packet_transmitter: all cycle parameters must be >= 1");
        end
    endgenerate

    logic [7:0]    r_sync1;
    logic [7:0]    r_sync2;
    logic [7:0]    w_filt;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    r_last;
    logic [7:0]    w_last_nxt;
    logic [RW-1:0] r_ref;
    logic          r_pend;
    logic          r_txd;
    logic          w_txd_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          w_start;
    logic          w_pulse;
    logic          w_bit_end;
    logic          w_trigger;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef EVENT_TX_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] C_DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_deb
            logic [DW-1:0] r_cnt;
            logic          r_bit;
            // A bit only follows sync after DEBOUNCE_CYCLES consecutive disagreeing cycles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_bit <= 1'b0;
                end else if (r_sync2[gi] == r_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DEB_LAST) begin
                    r_cnt <= '0;
                    r_bit <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_filt[gi] = r_bit;
        end
    endgenerate
`else
    assign w_filt = r_sync2;
`endif

    assign w_bit_end = (r_timer == C_BIT_LAST);
    assign w_trigger = (w_filt != r_last) || (r_ref == C_REF_LAST) || r_pend;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_start     = 1'b0;
        w_pulse     = 1'b0;
        w_txd_nxt   = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                w_idx_nxt   = 3'd0;
                if (w_trigger) begin
                    w_start     = 1'b1;
                    w_shift_nxt = w_filt;
                    w_last_nxt  = w_filt;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_timer_nxt = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_pulse     = 1'b1;
                    w_timer_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // TxD is registered from the next state so the line never glitches.
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[w_idx_nxt];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_last  <= 8'h00;
            r_busy  <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // A request that lands on the frame-start edge is kept for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= force_send | (r_pend & ~w_start);
            if (w_start) begin
                r_ref <= '0;
            end else if (r_ref != C_REF_LAST) begin
                r_ref <= r_ref + 1'b1;
            end
        end
    end

    assign TxD        = r_txd;
    assign busy       = r_busy;
    assign sent_pulse = w_pulse;
    assign last_sent  = r_last;

endmodule
`default_nettype wire
